// File: rtl/arb_pkg.sv
// Shared definitions for the one-hot round-robin arbiter: state encodings,
// requester count and index helpers.
package arb_pkg;

    localparam int N_REQ    = 4;
    localparam int IDX_W    = $clog2(N_REQ);
    localparam int STATE_W  = 3;
    localparam int TO_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'b001,
        GRANT   = 3'b010,
        RELEASE = 3'b100
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit searching upward
// from (ptr+1) mod N_REQ, wrapping back around to ptr itself last.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        idx    = '0;
        valid  = |req;
        w_cand = '0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = ptr + IDX_W'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Four-requester round-robin arbiter with one-hot IDLE/GRANT/RELEASE FSM.
// Optional forced release after TIMEOUT_CYCLES grant cycles with macro ARB_TIMEOUT_EN.
module onehot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic               done,
    output logic [STATE_W-1:0] state,
    output logic [N_REQ-1:0]   grant,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               busy,
    output logic               timeout
);

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_gnt_id;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;

    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_valid;
    logic             w_owner_rel;
    logic             w_to_hit;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .idx   (w_win_idx),
        .valid (w_win_valid)
    );

    assign w_owner_rel = done | ~req[r_gnt_id];

`ifdef ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                r_timeout;

    // Counter value equals (grant cycle number - 1) while in GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == IDLE && w_win_valid) begin
            r_to_cnt <= '0;
        end else if (r_state == GRANT) begin
            r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
        end
    end

    assign w_to_hit = (r_state == GRANT) && (r_to_cnt == TO_LIMIT);
    assign timeout  = r_timeout;
`else
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= IDX_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_state  <= GRANT;
                        r_grant  <= idx_to_onehot(w_win_idx);
                        r_gnt_id <= w_win_idx;
                        r_busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_owner_rel || w_to_hit) begin
                        r_state <= RELEASE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_gnt_id;
`ifdef ARB_TIMEOUT_EN
                        // A genuine release in the limit cycle wins over the timeout.
                        r_timeout <= ~w_owner_rel;
`endif
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state  = r_state;
    assign grant  = r_grant;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule
